// File: rtl/relay_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : relay_frame_tx_if
//  Purpose  : Byte-wide valid/ready payload interface into relay_frame_tx.
//             The master (ARM-facing producer) drives the byte, its last flag
//             and valid; the slave (frame transmitter) returns ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface relay_frame_tx_if;
    logic [7:0] data_in;
    logic       data_last;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_last,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_last,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/relay_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : relay_frame_tx
//  Purpose  : Relay-link transmitter. Buffers payload bytes in a small FIFO,
//             wraps each frame in role-specific start/end markers and shifts
//             it MSB-first onto the relay line, one bit per bit tick.
//  Revision : 1.0 - initial release
// ============================================================================
module relay_frame_tx #(
    parameter int DEPTH      = 16,   // FIFO entries (power of 2, >= 2)
    parameter int TICK_DIV   = 16,   // clk cycles per relay bit
    parameter int TICK_PHASE = 8     // divider value at which a bit tick occurs
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          role_i,      // 1 = fake reader, 0 = fake tag
    relay_frame_tx_if.slave    byte_if,
    output logic               relay_out_o,
    output logic               busy_o,
    output logic               underrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Start markers are held left-aligned so both roles shift out of bit 7.
    localparam logic [7:0] C_READER_SOF = 8'hC0;  // 8 bits: 1100_0000
    localparam logic [7:0] C_TAG_SOF    = 8'hF0;  // 4 bits: 1111
    localparam logic [3:0] C_READER_SOF_LEN = 4'd7;
    localparam logic [3:0] C_TAG_SOF_LEN    = 4'd3;
    localparam logic [3:0] C_READER_EOF_LEN = 4'd15;
    localparam logic [3:0] C_TAG_EOF_LEN    = 4'd7;
    localparam logic [3:0] C_GAP_LEN        = 4'd7;
    localparam logic [3:0] C_BYTE_LEN       = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_PAYLOAD = 3'd2,
        S_END     = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic [DW-1:0]   div_d;
    logic [AW:0]     wr_q;
    logic [AW:0]     rd_q;
    logic [8:0]      mem_q [DEPTH];
    logic [7:0]      sh_q;
    logic [3:0]      cnt_q;
    logic            last_q;
    logic            role_q;
    logic            relay_out_q;
    logic            busy_q;
    logic            underrun_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic            w_tick;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic [8:0]      w_head;
    logic [7:0]      w_sof;

    // Pointers carry one extra wrap bit: equal => empty, only MSB differs => full.
    assign w_empty = (wr_q == rd_q);
    assign w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_push  = byte_if.data_valid && !w_full;
    assign w_head  = mem_q[rd_q[AW-1:0]];
    assign w_tick  = (div_q == DW'(TICK_PHASE));
    assign w_sof   = role_i ? C_READER_SOF : C_TAG_SOF;

    assign byte_if.data_ready = !w_full;
    assign relay_out_o        = relay_out_q;
    assign busy_o             = busy_q;
    assign underrun_o         = underrun_q;

    // Free-running bit-tick divider, wraps at TICK_DIV-1.
    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DW'(TICK_DIV - 1)) begin
            div_d = '0;
        end
    end

    // Divider register: restarts from zero on reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // FIFO storage: data byte plus its last flag.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q[AW-1:0]] <= {byte_if.data_last, byte_if.data_in};
        end
    end

    // FIFO write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
        end else if (w_push) begin
            wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Framing state machine; every state/bit change happens on a bit tick and
    // the new line bit is registered on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            role_q      <= 1'b0;
            relay_out_q <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (w_tick) begin
                case (state_q)
                    S_IDLE: begin
                        relay_out_q <= 1'b0;
                        if (!w_empty) begin
                            role_q      <= role_i;
                            busy_q      <= 1'b1;
                            relay_out_q <= w_sof[7];
                            sh_q        <= {w_sof[6:0], 1'b0};
                            cnt_q       <= role_i ? C_READER_SOF_LEN : C_TAG_SOF_LEN;
                            state_q     <= S_START;
                        end
                    end

                    S_START: begin
                        if (cnt_q != 4'd0) begin
                            relay_out_q <= sh_q[7];
                            sh_q        <= {sh_q[6:0], 1'b0};
                            cnt_q       <= cnt_q - 4'd1;
                        end else begin
                            // A frame only starts with data queued, so the pop is safe.
                            relay_out_q <= w_head[7];
                            sh_q        <= {w_head[6:0], 1'b0};
                            last_q      <= w_head[8];
                            rd_q        <= rd_q + {{AW{1'b0}}, 1'b1};
                            cnt_q       <= C_BYTE_LEN;
                            state_q     <= S_PAYLOAD;
                        end
                    end

                    S_PAYLOAD: begin
                        if (cnt_q != 4'd0) begin
                            relay_out_q <= sh_q[7];
                            sh_q        <= {sh_q[6:0], 1'b0};
                            cnt_q       <= cnt_q - 4'd1;
                        end else if (!last_q && !w_empty) begin
                            // Back-to-back byte, no idle bit in between.
                            relay_out_q <= w_head[7];
                            sh_q        <= {w_head[6:0], 1'b0};
                            last_q      <= w_head[8];
                            rd_q        <= rd_q + {{AW{1'b0}}, 1'b1};
                            cnt_q       <= C_BYTE_LEN;
                        end else begin
                            // Either a clean end or the producer ran dry mid-frame.
                            underrun_q  <= !last_q;
                            relay_out_q <= 1'b0;
                            cnt_q       <= role_q ? C_READER_EOF_LEN : C_TAG_EOF_LEN;
                            state_q     <= S_END;
                        end
                    end

                    S_END: begin
                        relay_out_q <= 1'b0;
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            cnt_q   <= C_GAP_LEN;
                            state_q <= S_GAP;
                        end
                    end

                    S_GAP: begin
                        relay_out_q <= 1'b0;
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end

                    default: begin
                        relay_out_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/relay_frame_tx.md
Name: relay_frame_tx

Overview:
- Transmit side of the relay link, feeding the relay line that the relay decoder/receiver consumes.
- Accepts payload bytes from the ARM-facing side through a valid/ready byte interface and buffers them in a small FIFO.
- Wraps each frame in the start and end markers for the selected role (fake reader or fake tag).
- Serialises the frame MSB-first onto the relay line at the 0.8475 MHz bit tick, i.e. one bit per 16 clk cycles.

Parameters:
- DEPTH, 16: FIFO depth in entries. Each entry is 8 data bits plus 1 last flag. Must be a power of 2, ≥2.
- TICK_DIV, 16: clk cycles per relay bit.
- TICK_PHASE, 8: value of the free-running divider at which a bit tick occurs.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- role, input, 1: 1 = fake reader framing, 0 = fake tag framing. Sampled only when leaving IDLE.
- data_in, input, 8: payload byte.
- data_last, input, 1: marks data_in as the final byte of the frame.
- data_valid, input, 1: data_in/data_last are valid.
- data_ready, output, 1: FIFO can accept a byte. Equals !full.
- relay_out, output, 1: serial relay line, registered.
- busy, output, 1: high in any state other than IDLE.
- underrun, output, 1: one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async, active-high):
  - FIFO is emptied; divider = 0; state = IDLE.
  - relay_out = 0, busy = 0, underrun = 0; data_ready = 1 immediately.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps; runs free from reset release.
  - tick = (divider == TICK_PHASE). With defaults, the first tick is the 9th rising edge after reset release, then every 16 cycles.
- Write side:
  - A byte is accepted on any cycle with data_valid & data_ready.
  - Write and read in the same cycle are both legal; the count is unchanged.
  - When full, data_ready = 0 and the producer holds its data; nothing is dropped.
- Output timing:
  - All state and bit changes happen only on tick.
  - relay_out takes the new bit in the same clock edge as the tick and holds it for TICK_DIV cycles.
- State machine (evaluated on tick):
  - IDLE: relay_out = 0. If the FIFO is non-empty: latch role into role_q, load the shift register with the start marker, go to START.
  - START:
    - Reader: 8 bits 0xC0, MSB first (1,1,0,0,0,0,0,0).
    - Tag: 4 bits 0xF (1,1,1,1).
    - After the last marker bit: pop one byte (the FIFO is guaranteed non-empty), go to PAYLOAD.
  - PAYLOAD: shift out 8 bits MSB first. After bit 0 of the byte:
    - Byte's last flag = 1: go to END.
    - Else FIFO non-empty: pop the next byte, stay in PAYLOAD with no idle bit between bytes.
    - Else (empty, no last seen): pulse underrun for 1 cycle, go to END.
  - END:
    - Reader: 16 bits 0x0000.
    - Tag: 8 bits 0x00.
    - Then go to GAP.
  - GAP: 8 bit-times of 0, then IDLE. This guarantees the receiver sees an end pattern before the next start marker.
- Bit counter: 4 bits, reloaded on each state entry; the state advances when it reaches 0.
- Role is held in role_q for the whole frame; changes on role mid-frame are ignored.
- A byte written during START, PAYLOAD, END or GAP is queued and belongs to the current frame only if it is popped before END. Otherwise it starts the next frame after GAP.
- A pop happens in the tick cycle. If a write hits an empty FIFO in that same cycle, it is not visible until the next tick: the underrun decision uses the pre-write count.
- Frame length in bits:
  - Reader: 8 + 8N + 16 + 8.
  - Tag: 4 + 8N + 8 + 8.
- FIFO pointers are log2(DEPTH)+1 bits wide with natural wrap; full/empty come from the MSB comparison.
- Reset mid-frame aborts immediately: relay_out = 0, FIFO contents are discarded, no underrun pulse.

Test Plan:
- Reader frame: role = 1, write 0x52 with last = 1 → busy rises at tick 1. relay_out over successive ticks is 11000000, 01010010, sixteen 0s, eight 0s, then IDLE. Total 40 bit-times; busy falls at the tick ending GAP.
- Tag frame: role = 0, write 0xA5 then 0x3C (last) → 1111, 10100101, 00111100, 00000000, gap of 8 zeros. underrun stays 0.
- Underrun: role = 1, write 0x81 without last, no further writes → 11000000, 10000001. underrun pulses once at the tick after the final payload bit; then 24 zeros; FIFO is empty afterwards.
- Full/backpressure: hold data_valid with bytes 0x00..0x10 and last on 0x10, DEPTH = 16, no tick consumption yet → data_ready falls after 16 accepts and 0x10 waits. After the first pop, data_ready rises and 0x10 is accepted; all 17 bytes are transmitted in order in one frame.
- Role change mid-frame: start a reader frame, toggle role to 0 during PAYLOAD → the end marker is still 16 zeros. The next frame uses the tag start marker 1111.
- Async reset in PAYLOAD: assert reset between clock edges → relay_out = 0, busy = 0 and data_ready = 1 without waiting for a clk edge. After release, the first tick is the 9th edge and relay_out stays 0 in IDLE.
